// File: rtl/hl_pkg.sv
// hl_pkg: shared types and constants for the hl_timer half-life / step timer.
//   state_t    : timer FSM states (IDLE, RUN, PAUSED, DONE)
//   MODE_*     : step-mode encodings for the 2-bit mode input
package hl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] MODE_HALVE   = 2'b00;
  localparam logic [1:0] MODE_DOWN    = 2'b01;
  localparam logic [1:0] MODE_UP_SAT  = 2'b10;
  localparam logic [1:0] MODE_UP_WRAP = 2'b11;

endpackage

// File: rtl/hl_prescaler.sv
// hl_prescaler: divides the clock by a latched period and emits a step tick.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clear    : zero the count and capture a new period (0 is stored as 1)
//   enable   : advance the count this cycle
//   period   : clocks per step, captured on clear
//   tick     : high when enabled and the count has reached period-1
module hl_prescaler #(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic [PW-1:0] period,
  output logic          tick
);

  logic [PW-1:0] count;
  logic [PW-1:0] period_q;

  assign tick = enable && (count == (period_q - PW'(1)));

  // The period is captured on every clear. The owner clears on both load and
  // start, but RUN is only ever entered through start, so the latched period
  // always reflects the value presented with the accepted start. A zero period
  // is stored as 1 so the compare above never underflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      period_q <= PW'(1);
    end else if (clear) begin
      count    <= '0;
      period_q <= (period == '0) ? PW'(1) : period;
    end else if (enable) begin
      count <= tick ? '0 : count + PW'(1);
    end
  end

endmodule

// File: rtl/hl_timer.sv
// hl_timer: loadable value register stepped once per prescaler period until it
// reaches the terminal value for the selected mode.
// Ports:
//   clk, rst  : clock and synchronous active-high reset (highest priority)
//   load      : load load_val, clear the prescaler, return to IDLE
//   load_val  : value to load
//   start     : begin stepping (accepted in IDLE or DONE only)
//   pause     : level; freezes prescaler and value while high in RUN
//   mode      : step mode, latched on an accepted start
//   period    : clocks per step, latched on an accepted start (0 acts as 1)
//   out       : registered current value
//   step      : one-cycle pulse while out shows a freshly stepped value
//   done      : high in DONE
//   busy      : high in RUN or PAUSED
module hl_timer
  import hl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic [1:0]       mode,
  input  logic [PW-1:0]    period,
  output logic [WIDTH-1:0] out,
  output logic             step,
  output logic             done,
  output logic             busy
);

  state_t           state, state_n;
  logic [WIDTH-1:0] value, value_n;
  logic [1:0]       mode_q, mode_n;
  logic             step_q, step_n;
  logic             clear, enable, tick;
  logic [WIDTH-1:0] stepped;

  function automatic logic is_terminal(input logic [WIDTH-1:0] v, input logic [1:0] m);
    case (m)
      MODE_HALVE, MODE_DOWN: return (v == '0);
      MODE_UP_SAT:           return (v == '1);
      default:               return 1'b0;
    endcase
  endfunction

  // DOWN and UP_SAT clamp at their end points so the value can never leave
  // range even if a step were requested at the terminal value.
  function automatic logic [WIDTH-1:0] step_value(input logic [WIDTH-1:0] v, input logic [1:0] m);
    case (m)
      MODE_HALVE:  return v >> 1;
      MODE_DOWN:   return (v == '0) ? v : v - WIDTH'(1);
      MODE_UP_SAT: return (v == '1) ? v : v + WIDTH'(1);
      default:     return v + WIDTH'(1);
    endcase
  endfunction

  assign stepped = step_value(value, mode_q);

  // The release cycle out of PAUSED counts toward the period, so a pause costs
  // exactly as many cycles as pause was held.
  assign enable = ((state == RUN) || (state == PAUSED)) && !pause;

  hl_prescaler #(.PW(PW)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .enable (enable),
    .period (period),
    .tick   (tick)
  );

  // Register stage for the FSM, value, latched mode and step pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      value  <= '0;
      mode_q <= MODE_HALVE;
      step_q <= 1'b0;
    end else begin
      state  <= state_n;
      value  <= value_n;
      mode_q <= mode_n;
      step_q <= step_n;
    end
  end

  // Command priority is load > start > pause > stepping. A value that is
  // already terminal when RUN is entered goes straight to DONE without a step.
  always_comb begin
    state_n = state;
    value_n = value;
    mode_n  = mode_q;
    step_n  = 1'b0;
    clear   = 1'b0;
    if (load) begin
      value_n = load_val;
      clear   = 1'b1;
      state_n = IDLE;
    end else if (start && ((state == IDLE) || (state == DONE))) begin
      mode_n  = mode;
      clear   = 1'b1;
      state_n = RUN;
    end else begin
      case (state)
        RUN, PAUSED: begin
          if (pause) begin
            state_n = PAUSED;
          end else begin
            state_n = RUN;
            if (is_terminal(value, mode_q)) begin
              state_n = DONE;
            end else if (tick) begin
              value_n = stepped;
              step_n  = 1'b1;
              if (is_terminal(stepped, mode_q)) state_n = DONE;
            end
          end
        end
        default: state_n = state;
      endcase
    end
  end

  assign out  = value;
  assign step = step_q;
  assign done = (state == DONE);
  assign busy = (state == RUN) || (state == PAUSED);

endmodule

// File: doc/hl_timer.md
# hl_timer

Parametrised half-life / step timer, the next generation of the 4-bit up/down/load counter. A value register is loaded, then stepped once every `period` clocks until it reaches a terminal value. Each step either halves the value (exponential decay) or counts down, up-saturating or up-wrapping. The block sits beside the existing counters and drives display and interrupt logic through `out`, `step`, `done` and `busy`.

## Interface
- `WIDTH`, default 8: width of the value register and of `out`; minimum 2.
- `PW`, default 16: width of the `period` input and of the internal prescaler.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset; highest priority.
- `load` input, 1 bit: copy `load_val` into the value register and return to IDLE.
- `load_val` input, WIDTH bits: value to load.
- `start` input, 1 bit: begin stepping from the current value.
- `pause` input, 1 bit: level input; freezes the prescaler and value while high in RUN.
- `mode` input, 2 bits: step mode, sampled only when `start` is accepted.
- `period` input, PW bits: clocks per step, sampled only when `start` is accepted; 0 is treated as 1.
- `out` output, WIDTH bits: current value, registered.
- `step` output, 1 bit: one-cycle pulse, high in the cycle in which `out` shows a newly stepped value.
- `done` output, 1 bit: high in DONE.
- `busy` output, 1 bit: high in RUN or PAUSED.

## Operation
- States: IDLE, RUN, PAUSED, DONE.
- Reset values: state IDLE, `out`=0, prescaler=0, latched mode=0, latched period=1, `step`=0, `done`=0, `busy`=0.
- Command priority on each edge, highest first: `rst` > `load` > `start` > `pause` > normal stepping.
- `load`, accepted in any state:
  - value <= `load_val`, prescaler <= 0, state <= IDLE, `step`=0.
- `start`, accepted in IDLE or DONE:
  - Latch `mode` and `period`; prescaler <= 0; state <= RUN.
  - If the value is already terminal for the latched mode, the state goes to DONE on the next edge and no `step` pulse is produced.
  - `start` in RUN or PAUSED is ignored.
- Modes:
  - 00 HALVE: value >> 1; terminal value 0.
  - 01 DOWN: value − 1; terminal value 0.
  - 10 UP_SAT: value + 1; terminal value all-ones.
  - 11 UP_WRAP: value + 1 modulo 2^WIDTH; no terminal value, so the block never enters DONE and `step` pulses on every rollover as well.
- RUN:
  - The prescaler increments each cycle.
  - When the prescaler equals (period−1), on that edge: value steps, prescaler <= 0, `step` <= 1.
  - If the stepped value is terminal, state <= DONE on the same edge.
- RUN with `pause`=1: state <= PAUSED; prescaler and value hold.
- PAUSED with `pause`=0: state <= RUN; the prescaler resumes from its held count.
- DONE: the value holds and `done` stays high until `load`, `start` or `rst`.
- Arithmetic stays within WIDTH bits. DOWN never steps below 0, and UP_SAT never steps past all-ones.

## Timing
- `start` accepted at edge E0. The first step lands at edge E0+P, where P = max(period, 1). Step k lands at E0+k·P, excluding paused cycles.
- `step` is registered and high for exactly the one cycle after each stepping edge. `done` rises in the same cycle as the final `step`.
- With P=1 a step occurs on every RUN edge, so `step` stays continuously high.
- `load` and `start` in the same cycle: `load` wins and `start` is dropped.
- `load` together with a stepping edge: `load` wins and no `step` pulse occurs.
- `rst` mid-RUN: all registers return to reset values on that edge.
- Changing `period` or `mode` while in RUN has no effect.

## Structure
- Package `hl_pkg` holds:
  - the state enum (IDLE, RUN, PAUSED, DONE);
  - the mode constants MODE_HALVE, MODE_DOWN, MODE_UP_SAT, MODE_UP_WRAP.
- Sub-module `hl_prescaler` (parameter PW) contains the prescaler counter, the period latch and the period-0-as-1 rule.
  - Inputs: `clk`, `rst`, `clear`, `enable`, `period`.
  - Output: `tick`, high when the count equals period−1 and `enable` is high.
- The top level holds the FSM, the value register and the step arithmetic.

## Test plan
- WIDTH=8, load 0x80, start with mode HALVE and period=3:
  - `out` = 0x40, 0x20, …, 0x01, 0x00 at E0+3, +6, …, +24.
  - 8 `step` pulses; `done` rises at E0+24.
- Load 0x02, start with mode DOWN and period=0:
  - `out` = 0x01 at E0+1 and 0x00 at E0+2; `done` at E0+2; `step` high for 2 consecutive cycles.
- Load 0xFE, start with mode UP_WRAP and period=1:
  - `out` = 0xFF, 0x00, 0x01, …; `done` never rises.
- Load 0x00, start with mode HALVE:
  - `done` at E0+1 with no `step` pulse.
  - Repeat with mode UP_SAT, load 0xFF: same response.
- HALVE with period=4, load 0x10:
  - `pause` high for 5 cycles starting at E0+2, so the first step moves to E0+9.
  - `busy`=1 throughout the pause.
- While in RUN:
  - Assert `load`=1 and `start`=1 together with `load_val`=0x33: state goes to IDLE, `out`=0x33, `busy`=0.
  - Then assert `rst`: `out`=0, `done`=0.
